pattern_sequencer: RTL and testbench

Controller that sequences the team's VGA pattern generators. It takes the pixel coordinates from the timing block and the 3-bit RGB outputs of N_PAT pattern generators, and selects which pattern is driven to the DAC. Pattern changes happen only at frame boundaries, either on a manual "next" request or automatically every FRAMES_PER_PAT frames. Output is registered and blanked outside the active area.

---
 rtl/pattern_sequencer.sv | 165 ++++++++++++++++
 tb/tb_pattern_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pattern_sequencer
// Description : Selects one of N_PAT VGA pattern generator outputs and drives
//               it to the DAC. Pattern changes occur only at frame boundaries,
//               on a manual "next" request or automatically every
//               FRAMES_PER_PAT frames. Output is registered and blanked
//               outside the active area.
//               Optional build macro: PATSEQ_OVERLAY_EN (8x8 white indicator
//               square at rows 0..7, columns pat_sel*16 .. pat_sel*16+7).
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_sequencer #(
  parameter int N_PAT          = 4,
  parameter int FRAMES_PER_PAT = 60,
  parameter int H_ACTIVE       = 640,
  parameter int V_ACTIVE       = 480
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [9:0]                 row_i,
  input  logic [9:0]                 column_i,
  input  logic [3*N_PAT-1:0]         pat_rgb_i,
  input  logic                       next_i,
  input  logic                       mode_i,
  output logic [2:0]                 rgb_o,
  output logic [$clog2(N_PAT)-1:0]   pat_sel_o,
  output logic                       frame_tick_o
);

  localparam int SW = $clog2(N_PAT);
  localparam int CW = $clog2(FRAMES_PER_PAT) + 1;

  localparam logic [SW-1:0] c_sel_last = SW'(N_PAT - 1);
  localparam logic [CW-1:0] c_cnt_term = CW'(FRAMES_PER_PAT - 1);
  localparam logic [9:0]    c_h_active = 10'(H_ACTIVE);
  localparam logic [9:0]    c_v_active = 10'(V_ACTIVE);

  typedef enum logic [1:0] {
    S_SYNC   = 2'd0,
    S_MANUAL = 2'd1,
    S_AUTO   = 2'd2
  } state_t;

  state_t          r_state;
  logic [SW-1:0]   r_pat_sel;
  logic [CW-1:0]   r_cnt;
  logic            r_pending;
  logic            r_next_q;
  logic            r_prev_origin;
  logic [2:0]      r_rgb;
  logic            r_frame_tick;

  logic            w_origin;
  logic            w_tick;
  logic            w_next_rise;
  logic            w_pend_nxt;
  logic [SW-1:0]   w_sel_inc;
  state_t          w_state_nxt;
  logic [SW-1:0]   w_sel_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_active;
  logic [2:0]      w_pix;
  logic [2:0]      w_rgb_nxt;

  // Frame boundary and next-request edge detection
  always_comb begin
    w_origin    = (row_i == 10'd0) && (column_i == 10'd0);
    // Only the first cycle at (0,0) counts, so held coordinates give one tick
    w_tick      = w_origin && !r_prev_origin;
    w_next_rise = next_i && !r_next_q;
    // Every tick consumes (or discards) the outstanding request; an edge on
    // the tick cycle itself is kept for the following frame.
    w_pend_nxt  = w_tick ? w_next_rise : (r_pending || w_next_rise);
    w_sel_inc   = (r_pat_sel == c_sel_last) ? '0 : r_pat_sel + 1'b1;
  end

  // Next-state decision for the sequencing FSM, evaluated on frame ticks
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_pat_sel;
    w_cnt_nxt   = r_cnt;
    if (w_tick) begin
      case (r_state)
        S_SYNC: begin
          w_state_nxt = mode_i ? S_AUTO : S_MANUAL;
          w_cnt_nxt   = '0;
        end
        S_MANUAL: begin
          if (r_pending) begin
            w_sel_nxt = w_sel_inc;
          end
          if (mode_i) begin
            w_state_nxt = S_AUTO;
            w_cnt_nxt   = '0;
          end
        end
        S_AUTO: begin
          // Terminal count and a pending request together still advance once
          if ((r_cnt == c_cnt_term) || r_pending) begin
            w_sel_nxt = w_sel_inc;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
          if (!mode_i) begin
            w_state_nxt = S_MANUAL;
          end
        end
        default: begin
          w_state_nxt = S_SYNC;
          w_sel_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Pixel colour: next-state selection so a change shows from pixel (0,0)
  always_comb begin
    w_active = (row_i < c_v_active) && (column_i < c_h_active);
    w_pix    = 3'b000;
    for (int k = 0; k < N_PAT; k++) begin
      if (w_sel_nxt == SW'(k)) begin
        w_pix = pat_rgb_i[3*k +: 3];
      end
    end
`ifdef PATSEQ_OVERLAY_EN
    // Indicator square: 16-column slot per pattern, left 8 columns lit
    if ((row_i < 10'd8) && (column_i[9:4] == 6'(w_sel_nxt)) && !column_i[3]) begin
      w_pix = 3'b111;
    end
`endif
    w_rgb_nxt = (w_active && (w_state_nxt != S_SYNC)) ? w_pix : 3'b000;
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= S_SYNC;
      r_pat_sel     <= '0;
      r_cnt         <= '0;
      r_pending     <= 1'b0;
      r_next_q      <= 1'b0;
      r_prev_origin <= 1'b0;
      r_rgb         <= 3'b000;
      r_frame_tick  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pat_sel     <= w_sel_nxt;
      r_cnt         <= w_cnt_nxt;
      r_pending     <= w_pend_nxt;
      r_next_q      <= next_i;
      r_prev_origin <= w_origin;
      r_rgb         <= w_rgb_nxt;
      r_frame_tick  <= w_tick;
    end
  end

  assign rgb_o        = r_rgb;
  assign pat_sel_o    = r_pat_sel;
  assign frame_tick_o = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_sequencer
// Description : Directed, table-driven bench for pattern_sequencer
//               (N_PAT=4, FRAMES_PER_PAT=2). Honours PATSEQ_OVERLAY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_sequencer;

  logic        clk;
  logic        rst_n;
  logic [9:0]  row;
  logic [9:0]  col;
  logic [11:0] pat;
  logic        nxt;
  logic        mode;
  logic [2:0]  rgb;
  logic [1:0]  sel;
  logic        tick;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [9:0] row;
    logic [9:0] col;
    logic       nxt;
    logic       mode;
    logic [2:0] rgb;   // pattern colour before any overlay
    logic       chk;   // compare rgb_o for this vector
    logic [1:0] sel;
    logic       tick;
  } vec_t;

  vec_t tbl[$];

  pattern_sequencer #(
    .N_PAT(4), .FRAMES_PER_PAT(2), .H_ACTIVE(640), .V_ACTIVE(480)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .row_i(row), .column_i(col),
    .pat_rgb_i(pat), .next_i(nxt), .mode_i(mode),
    .rgb_o(rgb), .pat_sel_o(sel), .frame_tick_o(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void add(int r, int c, bit n, bit m, int rgb_e, bit ck, int sel_e, bit tk);
    vec_t v;
    v.row = 10'(r); v.col = 10'(c); v.nxt = n; v.mode = m;
    v.rgb = 3'(rgb_e); v.chk = ck; v.sel = 2'(sel_e); v.tick = tk;
    tbl.push_back(v);
  endfunction

  // Expected colour including the optional indicator square
  function automatic logic [2:0] exp_rgb(logic [9:0] r, logic [9:0] c, logic [1:0] s, logic [2:0] base);
`ifdef PATSEQ_OVERLAY_EN
    if (r < 10'd8 && c < 10'd640 && c[9:4] == {4'd0, s} && !c[3]) return 3'b111;
`endif
    return base;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic run_vec(vec_t v, string tag);
    row = v.row; col = v.col; nxt = v.nxt; mode = v.mode;
    @(posedge clk); #1;
    if (v.chk) check({tag, " rgb"}, 32'(rgb), 32'(exp_rgb(v.row, v.col, v.sel, v.rgb)));
    check({tag, " sel"}, 32'(sel), 32'(v.sel));
    check({tag, " tick"}, 32'(tick), 32'(v.tick));
  endtask

  initial begin
    // pat3=011 pat2=001 pat1=100 pat0=010
    pat = {3'b011, 3'b001, 3'b100, 3'b010};
    rst_n = 1'b0; row = 10'd100; col = 10'd200; nxt = 1'b0; mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset rgb", 32'(rgb), 0);
    check("reset sel", 32'(sel), 0);
    check("reset tick", 32'(tick), 0);
    rst_n = 1'b1;

    // ---- manual mode: three edges in one frame give one advance, then wrap
    add(100,200,0,0,0,1,0,0);
    add(  0,  0,0,0,0,0,0,1);
    add(  0,  1,0,0,2,1,0,0);
    add(100,200,1,0,2,1,0,0); add(100,201,0,0,2,1,0,0);
    add(100,202,1,0,2,1,0,0); add(100,203,0,0,2,1,0,0);
    add(100,204,1,0,2,1,0,0); add(100,205,0,0,2,1,0,0);
    add(  0,  0,0,0,4,1,1,1);
    add(  0,  0,0,0,4,1,1,0);   // held origin: no second tick
    add(  1,  0,1,0,4,1,1,0); add(  1,  1,0,0,4,1,1,0);
    add(  0,  0,0,0,1,1,2,1);
    add(  5,  5,1,0,1,1,2,0); add(  5,  6,0,0,1,1,2,0);
    add(  0,  0,0,0,3,1,3,1);
    add(  5,  5,1,0,3,1,3,0); add(  5,  6,0,0,3,1,3,0);
    add(  0,  0,0,0,2,1,0,1);   // wrap 3 -> 0
    add(  5,  5,1,0,2,1,0,0); add(  5,  6,0,0,2,1,0,0);
    add(  0,  0,0,0,4,1,1,1);
    // ---- blanking with pattern 1 selected
    add(479,639,0,0,4,1,1,0);
    add(480,  0,0,0,0,1,1,0);
    add(  0,640,0,0,0,1,1,0);
    add(479,  0,0,0,4,1,1,0);
    // ---- auto mode, advance every second tick
    add( 10, 10,0,1,4,1,1,0); add(  0,  0,0,1,4,1,1,1);   // enter auto
    add( 10, 10,0,1,4,1,1,0); add(  0,  0,0,1,4,1,1,1);
    add( 10, 10,0,1,4,1,1,0); add(  0,  0,0,1,1,1,2,1);
    add( 10, 10,0,1,1,1,2,0); add(  0,  0,0,1,1,1,2,1);
    add( 10, 10,0,1,1,1,2,0); add(  0,  0,0,1,3,1,3,1);
    add( 10, 10,0,1,3,1,3,0); add(  0,  0,0,1,3,1,3,1);
    add( 10, 10,0,1,3,1,3,0); add(  0,  0,0,1,2,1,0,1);
    add( 10, 10,0,1,2,1,0,0); add(  0,  0,0,1,2,1,0,1);
    // ---- collision: request during the frame closed by the terminal tick
    add( 10, 10,1,1,2,1,0,0); add( 10, 11,0,1,2,1,0,0);
    add(  0,  0,0,1,4,1,1,1);
    add( 10, 10,0,1,4,1,1,0); add(  0,  0,0,1,4,1,1,1);   // counter restarted
    add( 10, 10,0,1,4,1,1,0); add(  0,  0,0,1,1,1,2,1);
    // ---- request at a non-terminal count in auto mode
    add( 10, 10,1,1,1,1,2,0); add( 10, 11,0,1,1,1,2,0);
    add(  0,  0,0,1,3,1,3,1);
    add( 10, 10,0,1,3,1,3,0); add(  0,  0,0,1,3,1,3,1);
    // ---- back to manual: the terminal advance on that tick still applies
    add( 10, 10,0,0,3,1,3,0); add(  0,  0,0,0,2,1,0,1);
    add( 10, 10,0,0,2,1,0,0); add(  0,  0,0,0,2,1,0,1);
    add( 10, 10,0,0,2,1,0,0); add(  0,  0,0,0,2,1,0,1);
    // ---- select pattern 2 and probe the indicator square region
    add( 10, 10,1,0,2,1,0,0); add( 10, 11,0,0,2,1,0,0); add(0,0,0,0,4,1,1,1);
    add( 10, 10,1,0,4,1,1,0); add( 10, 11,0,0,4,1,1,0); add(0,0,0,0,1,1,2,1);
    add(  3, 35,0,0,1,1,2,0);
    add(  3, 40,0,0,1,1,2,0);
    add(  8, 35,0,0,1,1,2,0);
    add(100,200,0,0,1,1,2,0);

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("v%0d", i));

    // ---- asynchronous reset in the middle of a frame
    row = 10'd100; col = 10'd200; nxt = 1'b0; mode = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("midreset rgb", 32'(rgb), 0);
    check("midreset sel", 32'(sel), 0);
    check("midreset tick", 32'(tick), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    // A request made while syncing must be discarded
    run_vec('{row:10'd100, col:10'd200, nxt:1'b1, mode:1'b0, rgb:3'd0, chk:1'b1, sel:2'd0, tick:1'b0}, "rs0");
    run_vec('{row:10'd100, col:10'd201, nxt:1'b0, mode:1'b0, rgb:3'd0, chk:1'b1, sel:2'd0, tick:1'b0}, "rs1");
    run_vec('{row:10'd0,   col:10'd0,   nxt:1'b0, mode:1'b0, rgb:3'd0, chk:1'b0, sel:2'd0, tick:1'b1}, "rs2");
    run_vec('{row:10'd0,   col:10'd1,   nxt:1'b0, mode:1'b0, rgb:3'd2, chk:1'b1, sel:2'd0, tick:1'b0}, "rs3");
    run_vec('{row:10'd100, col:10'd200, nxt:1'b0, mode:1'b0, rgb:3'd2, chk:1'b1, sel:2'd0, tick:1'b0}, "rs4");
    run_vec('{row:10'd0,   col:10'd0,   nxt:1'b0, mode:1'b0, rgb:3'd2, chk:1'b1, sel:2'd0, tick:1'b1}, "rs5");
    run_vec('{row:10'd100, col:10'd200, nxt:1'b0, mode:1'b0, rgb:3'd2, chk:1'b1, sel:2'd0, tick:1'b0}, "rs6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
